// File: rtl/mram_ctrl_pkg.sv
// Shared definitions for the MRAM access controller: FSM encoding, default
// access timings and the ECC decoder error-code encodings.
package mram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_ACC,
        WR_ACC,
        REC
    } state_e;

    localparam int T_RD_DEF  = 3;
    localparam int T_WR_DEF  = 4;
    localparam int T_REC_DEF = 1;

    // ERR_CODE is {db,sb}; any code with the db bit set counts as double-bit.
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SB   = 2'b01;
    localparam logic [1:0] ERR_DB   = 2'b10;

    function automatic logic is_sb(input logic [1:0] code);
        return code == ERR_SB;
    endfunction

    function automatic logic is_db(input logic [1:0] code);
        return code[1];
    endfunction

    function automatic logic [3:0] timer_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/mram_acc_ctrl_if.sv
// Host-side request/response bundle of the MRAM access controller.
interface mram_acc_ctrl_if #(
    parameter int AW = 10
);
    logic          REQ;
    logic          WR;
    logic [AW-1:0] ADDR;
    logic [7:0]    WDATA;
    logic          CNT_CLR;
    logic          BUSY;
    logic          ACK;
    logic [7:0]    RDATA;
    logic [1:0]    RERR;
    logic [3:0]    RERR_ADD;
    logic [7:0]    SB_CNT;
    logic [7:0]    DB_CNT;

    modport master (
        output REQ, WR, ADDR, WDATA, CNT_CLR,
        input  BUSY, ACK, RDATA, RERR, RERR_ADD, SB_CNT, DB_CNT
    );

    modport slave (
        input  REQ, WR, ADDR, WDATA, CNT_CLR,
        output BUSY, ACK, RDATA, RERR, RERR_ADD, SB_CNT, DB_CNT
    );
endinterface

// File: rtl/mram_sat_cnt.sv
// 8-bit event counter that sticks at 255; clear wins over increment.
module mram_sat_cnt (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/mram_acc_ctrl.sv
// MRAM access sequencer: one setup cycle, a timed read or write pulse, then
// recovery; captures ECC decoder status on reads and counts corrected/uncorrectable errors.
module mram_acc_ctrl
    import mram_ctrl_pkg::*;
#(
    parameter int AW    = 10,
    parameter int T_RD  = T_RD_DEF,
    parameter int T_WR  = T_WR_DEF,
    parameter int T_REC = T_REC_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    mram_acc_ctrl_if.slave  host,
    output logic [AW-1:0]   MA,
    output logic            CEN,
    output logic            WEN,
    output logic [7:0]      DI,
    input  logic [7:0]      DO,
    input  logic [1:0]      ERR_CODE,
    input  logic [3:0]      ERR_BIT_ADD
);
    if (T_RD < 1 || T_RD > 15 || T_WR < 1 || T_WR > 15 || T_REC < 1 || T_REC > 15) begin : g_bad_timing
        $error("mram_acc_ctrl: T_RD, T_WR and T_REC must lie in 1..15");
    end

    localparam logic [3:0] RD_LOAD  = timer_load(T_RD);
    localparam logic [3:0] WR_LOAD  = timer_load(T_WR);
    localparam logic [3:0] REC_LOAD = timer_load(T_REC);

    state_e        state_q, state_d;
    logic [3:0]    timer_q, timer_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] ma_q, ma_d;
    logic [7:0]    di_q, di_d;
    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [1:0]    rerr_q, rerr_d;
    logic [3:0]    radd_q, radd_d;
    logic          rd_cap;
    logic [7:0]    sb_cnt, db_cnt;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wr_d    = wr_q;
        ma_d    = ma_q;
        di_d    = di_q;
        cen_d   = cen_q;
        wen_d   = wen_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        radd_d  = radd_q;
        rd_cap  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!busy_q && host.REQ) begin
                    ma_d    = host.ADDR;
                    wr_d    = host.WR;
                    di_d    = host.WDATA;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // CEN/WEN are registered, so they fall on the edge entering the access.
                cen_d   = 1'b0;
                wen_d   = ~wr_q;
                timer_d = wr_q ? WR_LOAD : RD_LOAD;
                state_d = wr_q ? WR_ACC : RD_ACC;
            end
            RD_ACC: begin
                if (timer_q == 4'd0) begin
                    rd_cap  = 1'b1;
                    rdata_d = DO;
                    rerr_d  = ERR_CODE;
                    radd_d  = ERR_BIT_ADD;
                    cen_d   = 1'b1;
                    ack_d   = 1'b1;
                    timer_d = REC_LOAD;
                    state_d = REC;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            WR_ACC: begin
                if (timer_q == 4'd0) begin
                    cen_d   = 1'b1;
                    wen_d   = 1'b1;
                    ack_d   = 1'b1;
                    timer_d = REC_LOAD;
                    state_d = REC;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            REC: begin
                if (timer_q == 4'd0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            default: begin
                cen_d   = 1'b1;
                wen_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            timer_q <= 4'd0;
            wr_q    <= 1'b0;
            ma_q    <= '0;
            di_q    <= 8'd0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'd0;
            rerr_q  <= 2'd0;
            radd_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            wr_q    <= wr_d;
            ma_q    <= ma_d;
            di_q    <= di_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            radd_q  <= radd_d;
        end
    end

    mram_sat_cnt u_sb_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (host.CNT_CLR),
        .inc (rd_cap && is_sb(ERR_CODE)),
        .cnt (sb_cnt)
    );

    mram_sat_cnt u_db_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (host.CNT_CLR),
        .inc (rd_cap && is_db(ERR_CODE)),
        .cnt (db_cnt)
    );

    assign MA            = ma_q;
    assign CEN           = cen_q;
    assign WEN           = wen_q;
    assign DI            = di_q;
    assign host.BUSY     = busy_q;
    assign host.ACK      = ack_q;
    assign host.RDATA    = rdata_q;
    assign host.RERR     = rerr_q;
    assign host.RERR_ADD = radd_q;
    assign host.SB_CNT   = sb_cnt;
    assign host.DB_CNT   = db_cnt;
endmodule

// File: doc/mram_acc_ctrl.md
MRAM_ACC_CTRL -- requirements
Module: mram_acc_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 10, MRAM word-address width.
REQ-002 The block SHALL have parameter T_RD, default 3, read-access cycles with CEN low; legal range 1..15.
REQ-003 The block SHALL have parameter T_WR, default 4, write-pulse cycles with CEN and WEN low; legal range 1..15.
REQ-004 The block SHALL have parameter T_REC, default 1, recovery cycles with CEN high after each access; legal range 1..15.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset: CLK  in  1  clock, rising edge; RST  in  1  asynchronous active-high reset.
REQ-006 The block SHALL have these host ports: REQ  in  1  access request; WR  in  1  1 = write, 0 = read; ADDR  in  AW  word address; WDATA  in  8  write data; CNT_CLR  in  1  error-counter clear.
REQ-007 The block SHALL have these host ports: BUSY  out  1  access in progress; ACK  out  1  completion pulse; RDATA  out  8  read data; RERR  out  2  {db,sb} flags of the last read; RERR_ADD  out  4  error bit address of the last read; SB_CNT  out  8  single-bit error count; DB_CNT  out  8  double-bit error count.
REQ-008 The block SHALL have these MRAM/ECC-side ports: MA  out  AW  MRAM address; CEN  out  1  chip enable, active low; WEN  out  1  write enable, active low; DI  out  8  data to ECC encoder; DO  in  8  data from ECC decoder; ERR_CODE  in  2  {db,sb}; ERR_BIT_ADD  in  4  from decoder.

Function
REQ-009 The FSM SHALL have states IDLE, SETUP, RD_ACC, WR_ACC and REC, plus a 4-bit timer.
REQ-010 In IDLE, with BUSY=0 and REQ=1 at an edge, the block SHALL register ADDR, WR and WDATA into MA, an internal wr flag and DI, and SHALL move to SETUP.
REQ-011 BUSY SHALL be 1 in every state other than IDLE; REQ SHALL be ignored while BUSY=1.
REQ-012 SETUP SHALL last 1 cycle with CEN=1 and WEN=1, then go to RD_ACC if wr=0, else to WR_ACC.
REQ-013 RD_ACC SHALL hold CEN=0 and WEN=1 for exactly T_RD cycles.
REQ-014 On the edge that ends the last RD_ACC cycle, the block SHALL capture DO into RDATA, ERR_CODE into RERR and ERR_BIT_ADD into RERR_ADD.
REQ-015 WR_ACC SHALL hold CEN=0 and WEN=0 for exactly T_WR cycles, with MA and DI stable throughout; RDATA, RERR and RERR_ADD SHALL stay unchanged.
REQ-016 REC SHALL hold CEN=1 and WEN=1 for T_REC cycles, then return to IDLE.
REQ-017 ACK SHALL be high for exactly the first REC cycle.
REQ-018 Latency SHALL be as follows, with the REQ-sampling edge as cycle 0: SETUP in cycle 1; access in cycles 2..T+1; ACK in cycle T+2; IDLE in cycle T+T_REC+2.
REQ-019 MA, DI and WEN SHALL change only at IDLE-to-SETUP and at access boundaries, and never while CEN=0 except for WEN itself.
REQ-020 At each read capture, SB_CNT SHALL increment if ERR_CODE=01, and DB_CNT SHALL increment if ERR_CODE[1]=1.
REQ-021 Both counters SHALL saturate at 255, and writes SHALL never change either counter.
REQ-022 CNT_CLR=1 SHALL zero both counters on the next edge and SHALL take priority over a simultaneous increment.
REQ-023 CNT_CLR SHALL not affect the FSM.

Reset
REQ-024 While RST=1, asynchronously: state=IDLE, timer=0, CEN=1, WEN=1, MA=0, DI=0, BUSY=0, ACK=0, RDATA=0, RERR=0, RERR_ADD=0, SB_CNT=0, DB_CNT=0.
REQ-025 RST asserted mid-access SHALL abort the access without an ACK.
REQ-026 The first edge after RST deasserts SHALL be able to accept REQ.

Structure
REQ-027 The shared package mram_ctrl_pkg SHALL hold the state encoding, the default T_RD, T_WR and T_REC constants, and the ERR_CODE encodings (00 none, 01 sb, 1x db).
REQ-028 One sub-module, mram_sat_cnt (8-bit saturating counter with clear and increment), SHALL be instantiated twice.
REQ-029 Elaboration SHALL fail if any timing parameter is outside 1..15.

Verification
REQ-030 Read at ADDR=0x155, ERR_CODE=00, DO=0xA5, defaults -> CEN low in cycles 2..4; ACK in cycle 5; RDATA=0xA5; RERR=00; counters unchanged; BUSY=0 from cycle 6.
REQ-031 Write of 0x3C to ADDR=0x2AA -> WEN=CEN=0 in cycles 2..5; MA=0x2AA and DI=0x3C stable; ACK in cycle 6; RDATA unchanged.
REQ-032 Read with ERR_CODE=01 and ERR_BIT_ADD=0x7 -> RERR=01, RERR_ADD=0x7, SB_CNT=1; then a read with ERR_CODE=10 -> DB_CNT=1.
REQ-033 300 reads with ERR_CODE=01 -> SB_CNT=255; CNT_CLR asserted on the capture edge of a further ERR_CODE=01 read -> SB_CNT=0.
REQ-034 REQ held high continuously -> requests accepted only in IDLE, one access per T+T_REC+2 cycles, and no REQ accepted while BUSY=1.
REQ-035 RST pulsed in cycle 3 of a write -> CEN=WEN=1 immediately, no ACK, BUSY=0, and a new read completes normally.
